// File: rtl/fetch_unit.sv
// Purpose: instruction-fetch stage; owns PC and page base, reads a synchronous imem, presents Endereco/Instrucao.
// Latency: 3 cycles per instruction (FETCH -> WAIT -> EXEC); memory data is captured the cycle after MemRdEn.
// Backpressure: none; the datapath stops fetch with Halt and the OS/BIOS restarts it with CtxLoad.
// Optional feature: define PAGE_LIMIT_EN to add the CtxLimit input, the Fault output and the PC page-limit check.
// Ports: Clock/Reset (async active-low); NextPC, Halt from the datapath; CtxLoad/CtxPC/CtxBase[/CtxLimit] for
//   process switches; MemRdEn/MemAddr/MemData to imem; Endereco, Instrucao, CommitEn, Halted[, Fault] to the datapath.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       NextPC,
  input  logic              Halt,
  input  logic              CtxLoad,
  input  logic [31:0]       CtxPC,
  input  logic [31:0]       CtxBase,
`ifdef PAGE_LIMIT_EN
  input  logic [31:0]       CtxLimit,
  output logic              Fault,
`endif
  output logic              MemRdEn,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       MemData,
  output logic [31:0]       Endereco,
  output logic [31:0]       Instrucao,
  output logic              CommitEn,
  output logic              Halted
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] base;
  logic        exec_q;

  // Next-fetch selection: every path into FETCH goes through here so the
  // read enable and physical address can be registered on the way in.
  logic        ctx_take;
  logic        start_fetch;
  logic [31:0] nxt_pc;
  logic [31:0] nxt_base;
  logic [31:0] fetch_sum;
  logic        fetch_ok;
  logic        unused_sum;
`ifdef PAGE_LIMIT_EN
  logic [31:0] limit;
  logic [31:0] nxt_limit;
`endif

  // A context load is ignored while IDLE (the first fetch after reset wins).
  assign ctx_take = CtxLoad && (state != S_IDLE);

  always_comb begin
    start_fetch = 1'b0;
    nxt_pc      = pc;
    nxt_base    = base;
`ifdef PAGE_LIMIT_EN
    nxt_limit   = limit;
`endif
    if (ctx_take) begin
      start_fetch = 1'b1;
      nxt_pc      = CtxPC;
      nxt_base    = CtxBase;
`ifdef PAGE_LIMIT_EN
      nxt_limit   = CtxLimit;
`endif
    end else if (state == S_IDLE) begin
      start_fetch = 1'b1;
    end else if (state == S_EXEC && !Halt) begin
      start_fetch = 1'b1;
      nxt_pc      = NextPC;
    end
  end

  // Physical address wraps modulo 2^ADDR_W simply by truncating the sum.
  assign fetch_sum  = nxt_pc + nxt_base;
  assign unused_sum = ^fetch_sum;

`ifdef PAGE_LIMIT_EN
  assign fetch_ok = (nxt_pc < nxt_limit);
`else
  assign fetch_ok = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      base      <= '0;
      exec_q    <= 1'b0;
      MemRdEn   <= 1'b0;
      MemAddr   <= '0;
      Instrucao <= '0;
      Halted    <= 1'b0;
`ifdef PAGE_LIMIT_EN
      limit     <= 32'hFFFF_FFFF;
      Fault     <= 1'b0;
`endif
    end else begin
      MemRdEn <= 1'b0;
      exec_q  <= 1'b0;
      if (start_fetch) begin
        state   <= S_FETCH;
        pc      <= nxt_pc;
        base    <= nxt_base;
        MemRdEn <= fetch_ok;
        MemAddr <= fetch_sum[ADDR_W-1:0];
        Halted  <= 1'b0;
`ifdef PAGE_LIMIT_EN
        limit   <= nxt_limit;
        if (ctx_take) Fault <= 1'b0;
`endif
      end else begin
        case (state)
          S_FETCH: begin
`ifdef PAGE_LIMIT_EN
            // Out-of-page PC: the read was already suppressed on entry.
            if (pc >= limit) begin
              Fault  <= 1'b1;
              Halted <= 1'b1;
              state  <= S_HALTED;
            end else
`endif
            state <= S_WAIT;
          end
          S_WAIT: begin
            Instrucao <= MemData;
            exec_q    <= 1'b1;
            state     <= S_EXEC;
          end
          S_EXEC: begin
            // Only reached here with Halt=1; the run case is start_fetch.
            Halted <= 1'b1;
            state  <= S_HALTED;
          end
          S_HALTED: state <= S_HALTED;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  // A context load in EXEC aborts the instruction in the same cycle.
  assign CommitEn = exec_q && !CtxLoad;
  assign Endereco = pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] NextPC;
  logic        Halt;
  logic        CtxLoad;
  logic [31:0] CtxPC;
  logic [31:0] CtxBase;
  logic [31:0] CtxLimit;
  logic        MemRdEn;
  logic [9:0]  MemAddr;
  logic [31:0] MemData = 32'd0;
  logic [31:0] Endereco;
  logic [31:0] Instrucao;
  logic        CommitEn;
  logic        Halted;
`ifdef PAGE_LIMIT_EN
  logic        Fault;
`endif

  always #5 Clock = ~Clock;

  fetch_unit #(.ADDR_W(10), .RESET_PC(32'd0)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .NextPC   (NextPC),
    .Halt     (Halt),
    .CtxLoad  (CtxLoad),
    .CtxPC    (CtxPC),
    .CtxBase  (CtxBase),
`ifdef PAGE_LIMIT_EN
    .CtxLimit (CtxLimit),
    .Fault    (Fault),
`endif
    .MemRdEn  (MemRdEn),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
    .Endereco (Endereco),
    .Instrucao(Instrucao),
    .CommitEn (CommitEn),
    .Halted   (Halted)
  );

  // Synchronous instruction memory: data appears the cycle after the read.
  logic [31:0] mem [0:1023];
  always @(posedge Clock)
    MemData <= MemRdEn ? mem[MemAddr] : $urandom;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, instruction-level view: where we are inside the
  // current 3-cycle instruction, plus the architectural context.
  bit          m_started;
  bit          m_stopped;
  int          m_step;
  logic [31:0] m_pc, m_base, m_limit, m_instr;
  bit          m_fault;

  function automatic bit m_fetch_ok();
`ifdef PAGE_LIMIT_EN
    return m_pc < m_limit;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_started = 0; m_stopped = 0; m_step = 0;
    m_pc = 32'd0; m_base = 32'd0; m_limit = 32'hFFFF_FFFF; m_instr = 32'd0; m_fault = 0;
  endtask

  // Compare process: outputs checked every cycle, then model advanced one clock.
  always @(negedge Clock) begin
    bit exp_rd;
    #1;
    if (!Reset) model_reset();
    exp_rd = Reset && m_started && !m_stopped && m_step == 0 && m_fetch_ok();
    check("Endereco", Endereco, m_pc);
    check("Instrucao", Instrucao, m_instr);
    check("MemRdEn", {31'd0, MemRdEn}, {31'd0, exp_rd});
    if (exp_rd) check("MemAddr", {22'd0, MemAddr}, (m_pc + m_base) % 32'd1024);
    if (!Reset) check("MemAddr_rst", {22'd0, MemAddr}, 32'd0);
    check("CommitEn", {31'd0, CommitEn},
          {31'd0, Reset && m_started && !m_stopped && m_step == 2 && !CtxLoad});
    check("Halted", {31'd0, Halted}, {31'd0, m_stopped});
`ifdef PAGE_LIMIT_EN
    check("Fault", {31'd0, Fault}, {31'd0, m_fault});
`endif
    if (!Reset) begin
      // held in reset across the coming edge
    end else if (!m_started) begin
      m_started = 1; m_step = 0;
    end else if (CtxLoad) begin
      m_pc = CtxPC; m_base = CtxBase; m_limit = CtxLimit;
      m_fault = 0; m_stopped = 0; m_step = 0;
    end else if (m_stopped) begin
      // waits for a context load
    end else if (m_step == 0) begin
      if (!m_fetch_ok()) begin m_fault = 1; m_stopped = 1; end
      else m_step = 1;
    end else if (m_step == 1) begin
      m_instr = mem[(m_pc + m_base) % 32'd1024];
      m_step = 2;
    end else begin
      if (Halt) m_stopped = 1;
      else begin m_pc = NextPC; m_step = 0; end
    end
  end

  initial begin
    int  ncommit;
    bit  rd_seen;
    bit  found;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0005;
    model_reset();
    Reset = 0; Halt = 0; CtxLoad = 0; NextPC = 0; CtxPC = 0; CtxBase = 0; CtxLimit = 32'hFFFF_FFFF;

    repeat (2) @(negedge Clock);
    #2;
    check("rst_instr", Instrucao, 32'd0);
    check("rst_pc", Endereco, 32'd0);
    check("rst_rden", {31'd0, MemRdEn}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd0);

    @(negedge Clock); Reset = 1;  // IDLE cycle
    ncommit = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock); NextPC = m_pc + 1;
      #2;
      if (c == 1) begin
        check("first_rden", {31'd0, MemRdEn}, 32'd1);
        check("first_addr", {22'd0, MemAddr}, 32'd0);
      end
      if (c == 2) check("wait_no_rd", {31'd0, MemRdEn}, 32'd0);
      if (c == 3) check("first_instr", Instrucao, 32'h2001_0005);
      if (CommitEn) begin
        check("commit_cycle", c, 3 * (ncommit + 1));
        check("commit_pc", Endereco, ncommit);
        ncommit++;
      end
    end
    check("commit_count", ncommit, 4);

    // Context switch while fetching pc 4.
    @(negedge Clock); CtxLoad = 1; CtxPC = 2; CtxBase = 100;
    @(negedge Clock); CtxLoad = 0; #2;
    check("ctx_rden", {31'd0, MemRdEn}, 32'd1);
    check("ctx_addr", {22'd0, MemAddr}, 32'd102);
    check("ctx_pc", Endereco, 32'd2);

    // Halt in EXEC.
    @(negedge Clock);
    @(negedge Clock); Halt = 1; #2;
    check("halt_commit", {31'd0, CommitEn}, 32'd1);
    rd_seen = 0;
    repeat (4) begin @(negedge Clock); Halt = 0; #2; rd_seen |= MemRdEn; end
    check("halted", {31'd0, Halted}, 32'd1);
    check("halt_no_rd", {31'd0, rd_seen}, 32'd0);
    @(negedge Clock); CtxLoad = 1; CtxPC = 0; CtxBase = 0;
    @(negedge Clock); CtxLoad = 0; #2;
    check("resume_halted", {31'd0, Halted}, 32'd0);
    check("resume_rden", {31'd0, MemRdEn}, 32'd1);
    check("resume_addr", {22'd0, MemAddr}, 32'd0);

    // CtxLoad and Halt together in EXEC.
    @(negedge Clock);
    @(negedge Clock); CtxLoad = 1; Halt = 1; CtxPC = 5; CtxBase = 0; #2;
    check("both_commit", {31'd0, CommitEn}, 32'd0);
    @(negedge Clock); CtxLoad = 0; Halt = 0; #2;
    check("both_halted", {31'd0, Halted}, 32'd0);
    check("both_rden", {31'd0, MemRdEn}, 32'd1);
    check("both_addr", {22'd0, MemAddr}, 32'd5);

    // Address wrap, loaded while in WAIT.
    @(negedge Clock); CtxLoad = 1; CtxPC = 6; CtxBase = 1020;
    @(negedge Clock); CtxLoad = 0; #2;
    check("wrap_addr", {22'd0, MemAddr}, 32'd2);
    check("wrap_pc", Endereco, 32'd6);

`ifdef PAGE_LIMIT_EN
    @(negedge Clock); CtxLoad = 1; CtxPC = 4; CtxBase = 0; CtxLimit = 4;
    @(negedge Clock); CtxLoad = 0; CtxLimit = 32'hFFFF_FFFF; #2;
    check("limit_no_rd", {31'd0, MemRdEn}, 32'd0);
    @(negedge Clock); #2;
    check("limit_fault", {31'd0, Fault}, 32'd1);
    check("limit_halted", {31'd0, Halted}, 32'd1);
    @(negedge Clock); CtxLoad = 1; CtxPC = 0;
    @(negedge Clock); CtxLoad = 0; #2;
    check("limit_clear", {31'd0, Fault}, 32'd0);
`endif

    // Reset during EXEC: no commit, immediate reset values.
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge Clock); NextPC = m_pc + 1;
      if (m_started && !m_stopped && m_step == 2) begin Reset = 0; found = 1; end
    end
    #2;
    check("exec_found", {31'd0, found}, 32'd1);
    check("rst_exec_commit", {31'd0, CommitEn}, 32'd0);
    check("rst_exec_pc", Endereco, 32'd0);
    check("rst_exec_instr", Instrucao, 32'd0);
    @(negedge Clock); Reset = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      Reset    = ($urandom_range(0, 199) != 0);
      Halt     = ($urandom_range(0, 5) == 0);
      CtxLoad  = m_stopped ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      CtxPC    = $urandom_range(0, 1500);
      CtxBase  = $urandom_range(0, 2047);
`ifdef PAGE_LIMIT_EN
      CtxLimit = $urandom_range(0, 1600);
`else
      CtxLimit = $urandom;
`endif
      NextPC   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3000) : m_pc + 1;
    end
    @(negedge Clock); Reset = 1; CtxLoad = 0; Halt = 0;
    @(negedge Clock); #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
